// File: rtl/alu_issue_ctrl_if.sv
// Issue-side, ALU-side and response-side signals of alu_issue_ctrl.
// slave = the controller, master = the environment (decode/ALU/consumer).
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_mux;
    logic [1:0]  set_flag;
    logic [1:0]  a_op;
    logic        zero_b;
    logic [1:0]  shift_mode;
    logic        add_mode;
    logic [15:0] alu_out;
    logic [15:0] alu_rem;
    logic        div_stall;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [15:0] res_rem;
    logic        res_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  alu_out, alu_rem, div_stall,
        input  res_ready,
        output in_ready,
        output alu_a, alu_b, alu_mux, set_flag, a_op, zero_b, shift_mode, add_mode,
        output res_valid, res_data, res_rem, res_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b,
        output alu_out, alu_rem, div_stall,
        output res_ready,
        input  in_ready,
        input  alu_a, alu_b, alu_mux, set_flag, a_op, zero_b, shift_mode, add_mode,
        input  res_valid, res_data, res_rem, res_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: decodes a 4-bit op, holds operands/controls stable, returns one result.
// Latency: 2 cycles accept->res_valid; DIV waits on div_stall up to DIV_MAX_CYCLES (then error response).
// Backpressure: holds result until res_ready; in_ready only in IDLE or RESP&&res_ready. DIV_ZERO_TRAP_EN traps DIV by zero.
module alu_issue_ctrl #(
    parameter int DIV_MAX_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DIV_WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0] alu_mux;
        logic [1:0] a_op;
        logic       add_mode;
        logic [1:0] set_flag;
        logic [1:0] shift_mode;
    } ctrl_t;

    localparam logic [2:0] MUX_DIV = 3'b011;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [15:0]       alu_a_q, alu_a_d;
    logic [15:0]       alu_b_q, alu_b_d;
    logic [15:0]       res_data_q, res_data_d;
    logic [15:0]       res_rem_q, res_rem_d;
    logic              res_err_q, res_err_d;
    logic              trap_q, trap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready;
    logic              accept;
    logic              trap_in;

    function automatic ctrl_t decode(input logic [3:0] op, input logic trap);
        ctrl_t c;
        c = '0;
        case (op)
            4'h0: ;
            4'h1: begin c.a_op = 2'b01; c.add_mode = 1'b1; end
            4'h2: c.alu_mux = 3'b100;
            4'h3: c.alu_mux = 3'b101;
            4'h4: c.alu_mux = 3'b110;
            4'h5: begin c.alu_mux = 3'b111; c.a_op = 2'b01; end
            4'h6: begin c.alu_mux = 3'b001; c.shift_mode = 2'b01; end
            4'h7: begin c.alu_mux = 3'b001; c.shift_mode = 2'b10; end
            4'h8: begin c.alu_mux = 3'b001; c.shift_mode = 2'b11; end
            4'h9: c.alu_mux = 3'b001;
            4'hA: c.alu_mux = 3'b010;
            // A trapped divide must never raise the ALU's divide enable
            4'hB: c.alu_mux = trap ? 3'b000 : MUX_DIV;
            4'hC: begin c.alu_mux = 3'b111; c.a_op = 2'b10; end
            4'hD: begin c.a_op = 2'b01; c.add_mode = 1'b1; c.set_flag = 2'b01; end
            4'hE: begin c.a_op = 2'b01; c.add_mode = 1'b1; c.set_flag = 2'b10; end
            4'hF: c.set_flag = 2'b11;
            default: ;
        endcase
        return c;
    endfunction

`ifdef DIV_ZERO_TRAP_EN
    assign trap_in = (bus.in_op == 4'hB) && (bus.in_b == 16'h0000);
`else
    assign trap_in = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) || ((state_q == RESP) && bus.res_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_data_d = res_data_q;
        res_rem_d  = res_rem_q;
        res_err_d  = res_err_q;
        trap_d     = trap_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                if (trap_q) begin
                    res_data_d = 16'hFFFF;
                    res_rem_d  = alu_a_q;
                    res_err_d  = 1'b1;
                    state_d    = RESP;
                end else if (ctrl_q.alu_mux == MUX_DIV) begin
                    // div_stall is ignored here: the divider may still show last op's ready
                    cnt_d   = CNT_W'(1);
                    state_d = DIV_WAIT;
                end else begin
                    res_data_d = bus.alu_out;
                    res_rem_d  = '0;
                    res_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            DIV_WAIT: begin
                if (!bus.div_stall) begin
                    res_data_d = bus.alu_out;
                    res_rem_d  = bus.alu_rem;
                    res_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q >= CNT_W'(DIV_MAX_CYCLES)) begin
                    res_data_d = 16'hFFFF;
                    res_rem_d  = '0;
                    res_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept is only possible from IDLE or a completing RESP, so it overrides the above
        if (accept) begin
            alu_a_d = bus.in_a;
            alu_b_d = bus.in_b;
            ctrl_d  = decode(bus.in_op, trap_in);
            trap_d  = trap_in;
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_data_q <= '0;
            res_rem_q  <= '0;
            res_err_q  <= 1'b0;
            trap_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_data_q <= res_data_d;
            res_rem_q  <= res_rem_d;
            res_err_q  <= res_err_d;
            trap_q     <= trap_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_mux    = ctrl_q.alu_mux;
    assign bus.set_flag   = ctrl_q.set_flag;
    assign bus.a_op       = ctrl_q.a_op;
    assign bus.zero_b     = 1'b0;
    assign bus.shift_mode = ctrl_q.shift_mode;
    assign bus.add_mode   = ctrl_q.add_mode;
    assign bus.res_valid  = (state_q == RESP);
    assign bus.res_data   = res_data_q;
    assign bus.res_rem    = res_rem_q;
    assign bus.res_err    = res_err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stand-in driven by the control fields, opcode-level reference model.
module tb_alu_issue_ctrl;
    localparam int DMAX = 40;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.DIV_MAX_CYCLES(DMAX), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: interprets the control fields; the divider busy line comes from the stimulus
    logic [15:0] ap, bp;
    logic [16:0] sum17;
    logic [31:0] rot;
    always_comb begin
        case (bus.a_op)
            2'b00:   ap = bus.alu_a;
            2'b01:   ap = ~bus.alu_a;
            2'b10:   ap = {bus.alu_a[7:0], 8'h00};
            default: ap = 16'h0000;
        endcase
        bp    = bus.zero_b ? 16'h0000 : bus.alu_b;
        sum17 = {1'b0, ap} + {1'b0, bp} + {16'h0000, bus.add_mode};
        rot   = {bus.alu_a, bus.alu_a} << bus.alu_b[3:0];
        bus.alu_out = 16'h0000;
        bus.alu_rem = 16'h0000;
        case (bus.alu_mux)
            3'b000: begin
                case (bus.set_flag)
                    2'b00:   bus.alu_out = sum17[15:0];
                    2'b01:   bus.alu_out = {15'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
                    2'b10:   bus.alu_out = {15'h0, $signed(bus.alu_a) <= $signed(bus.alu_b)};
                    default: bus.alu_out = {15'h0, sum17[16]};
                endcase
            end
            3'b001: begin
                case (bus.shift_mode)
                    2'b01:   bus.alu_out = bus.alu_a << bus.alu_b[3:0];
                    2'b10:   bus.alu_out = bus.alu_a >> bus.alu_b[3:0];
                    2'b11:   bus.alu_out = 16'($signed(bus.alu_a) >>> bus.alu_b[3:0]);
                    default: bus.alu_out = rot[31:16];
                endcase
            end
            3'b010:  bus.alu_out = 16'(bus.alu_a * bus.alu_b);
            3'b011: begin
                if (bus.alu_b == 16'h0000) begin
                    bus.alu_out = 16'hFFFF;
                    bus.alu_rem = bus.alu_a;
                end else begin
                    bus.alu_out = bus.alu_a / bus.alu_b;
                    bus.alu_rem = bus.alu_a % bus.alu_b;
                end
            end
            3'b100:  bus.alu_out = bus.alu_a & bus.alu_b;
            3'b101:  bus.alu_out = bus.alu_a | bus.alu_b;
            3'b110:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            default: bus.alu_out = ap;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Opcode-level expectation: result, remainder, error, accept->res_valid cycle window, expected alu_mux
    task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input int s, output logic [15:0] d, output logic [15:0] r,
                             output logic e, output int lo, output int hi, output logic [2:0] mux);
        logic [16:0] s17;
        d = 16'h0; r = 16'h0; e = 1'b0; lo = 2; hi = 2; mux = 3'b000;
        case (op)
            4'h0: d = a + b;
            4'h1: d = b - a;
            4'h2: d = a & b;
            4'h3: d = a | b;
            4'h4: d = a ^ b;
            4'h5: d = ~a;
            4'h6: d = a << b[3:0];
            4'h7: d = a >> b[3:0];
            4'h8: d = 16'($signed(a) >>> b[3:0]);
            4'h9: begin
                d = a;
                for (int i = 0; i < int'(b[3:0]); i++) d = {d[14:0], d[15]};
            end
            4'hA: d = 16'(a * b);
            4'hB: begin
                mux = 3'b011;
`ifdef DIV_ZERO_TRAP_EN
                if (b == 16'h0000) begin
                    mux = 3'b000; d = 16'hFFFF; r = a; e = 1'b1;
                end else
`endif
                if (s >= DMAX) begin
                    d = 16'hFFFF; r = 16'h0; e = 1'b1; lo = DMAX + 1; hi = DMAX + 2;
                end else begin
                    if (b == 16'h0000) begin d = 16'hFFFF; r = a; end
                    else begin d = a / b; r = a % b; end
                    lo = s + 3; hi = s + 3;
                end
            end
            4'hC: d = {a[7:0], 8'h00};
            4'hD: d = {15'h0, $signed(a) < $signed(b)};
            4'hE: d = {15'h0, $signed(a) <= $signed(b)};
            default: begin
                s17 = {1'b0, a} + {1'b0, b};
                d = {15'h0, s17[16]};
            end
        endcase
    endtask

    // Called at a negedge where the DUT can accept; returns at a negedge with res_ready=1 in RESP
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int s, input int r);
        logic [15:0] ed, er;
        logic        ee;
        logic [2:0]  emux;
        int          lo, hi, k;
        ref_model(op, a, b, s, ed, er, ee, lo, hi, emux);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        #1 check("accept_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.res_ready = (r == 0);
        k = 1;
        while (k <= 100) begin
            #1;
            if (bus.res_valid) break;
            check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (op == 4'hB) begin
                check("div_mux_held", 32'(bus.alu_mux), 32'(emux));
                check("div_a_held", 32'(bus.alu_a), 32'(a));
                check("div_b_held", 32'(bus.alu_b), 32'(b));
                bus.div_stall = (k >= 2) && (k - 2 < s);
            end else begin
                bus.div_stall = 1'($urandom_range(0, 1));
            end
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_op = 4'($urandom); bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
            @(negedge clk);
            k++;
        end
        bus.in_valid  = 1'b0;
        bus.div_stall = 1'b0;
        if (lo == hi) check("latency", 32'(k), 32'(lo));
        else          check("latency_window", 32'((k >= lo) && (k <= hi)), 32'd1);
        check("res_data", 32'(bus.res_data), 32'(ed));
        check("res_rem", 32'(bus.res_rem), 32'(er));
        check("res_err", 32'(bus.res_err), 32'(ee));
        check("resp_in_ready", 32'(bus.in_ready), 32'(bus.res_ready));
        for (int i = 0; i < r; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op = 4'($urandom); bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
            #1 check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            #1;
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_res_data", 32'(bus.res_data), 32'(ed));
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({tag, "_alu_mux"}, 32'(bus.alu_mux), 32'd0);
        check({tag, "_ctrl"}, 32'({bus.set_flag, bus.a_op, bus.zero_b, bus.shift_mode, bus.add_mode}), 32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_fields"}, 32'({bus.res_data, bus.res_rem[14:0], bus.res_err}), 32'd0);
        check({tag, "_res_rem_msb"}, 32'(bus.res_rem[15]), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 4'h0; bus.in_a = 16'h0; bus.in_b = 16'h0;
        bus.div_stall = 1'b0; bus.res_ready = 1'b1;
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(4'h0, 16'h1234, 16'h0011, 0, 0);
        idle();
        do_op(4'hB, 16'd100, 16'd7, 17, 0);
        idle();
        do_op(4'hB, 16'h0050, 16'h0003, 1000, 0);
        idle();
        do_op(4'hD, 16'd5, 16'd3, 0, 0);
        do_op(4'h4, 16'hFF00, 16'h0FF0, 0, 0);
        idle();
        do_op(4'h3, 16'hA500, 16'h005A, 0, 5);
        idle();

        // Reset asserted while the divider is busy
        bus.in_op = 4'hB; bus.in_a = 16'd100; bus.in_b = 16'd7; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.div_stall = 1'b1;
        repeat (4) @(negedge clk);
        check("middiv_mux", 32'(bus.alu_mux), 32'h3);
        check("middiv_valid", 32'(bus.res_valid), 32'd0);
        #2 rst = 1'b0;
        #1 check_cleared("middiv_rst");
        @(negedge clk);
        rst = 1'b1;
        bus.div_stall = 1'b0;
        @(negedge clk);
        do_op(4'h0, 16'h0101, 16'h0202, 0, 0);
        idle();

        do_op(4'hB, 16'd9, 16'd0, 3, 0);
        idle();

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (op == 4'hB && $urandom_range(0, 4) == 0) b = 16'h0000;
            do_op(op, a, b, int'($urandom_range(0, 25)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Single-issue sequencer in front of the CPU ALU.
- Accepts decoded ops over a valid/ready handshake, maps a 4-bit opcode onto the ALU control fields, and holds operands and controls stable for the whole operation, including the multi-cycle divide.
- Returns one result per op on a valid/ready response channel.
- Sits between decode/issue and the ALU.

Parameters:
- DIV_MAX_CYCLES, 40, divide-wait timeout in cycles; timeout forces an error response.
- CNT_W, 6, width of the divide-wait counter; must satisfy 2^CNT_W > DIV_MAX_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  op request
- in_ready  out  1  controller can accept an op
- in_op  in  4  opcode
- in_a  in  16  operand A
- in_b  in  16  operand B
- alu_a  out  16  registered operand A to ALU
- alu_b  out  16  registered operand B to ALU
- alu_mux  out  3  ALU result select
- set_flag  out  2  ALU flag mode
- a_op  out  2  ALU A pre-op
- zero_b  out  1  ALU B zeroing
- shift_mode  out  2  ALU shifter mode
- add_mode  out  1  ALU adder mode
- alu_out  in  16  ALU result
- alu_rem  in  16  ALU remainder
- div_stall  in  1  ALU divider busy
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  16  result
- res_rem  out  16  remainder; valid for DIV, 0 otherwise
- res_err  out  1  divide timeout or trapped divide-by-zero

Behaviour:
- Opcode map (field order: alu_mux / a_op / add_mode / set_flag / shift_mode; zero_b=0 always):
  - 0 ADD 000/00/0/00/00; 1 SUB (B-A) 000/01/1/00/00
  - 2 AND 100/00/0/00/00; 3 OR 101/00/0/00/00; 4 XOR 110/00/0/00/00
  - 5 NOT 111/01/0/00/00; 6 SLL 001/00/0/00/01; 7 SRL 001/00/0/00/10
  - 8 SRA 001/00/0/00/11; 9 ROL 001/00/0/00/00
  - A MUL 010/00/0/00/00; B DIV 011/00/0/00/00
  - C A<<8 111/10/0/00/00; D SLT 000/01/1/01/00; E SLE 000/01/1/10/00; F SCO 000/00/0/11/00
- States:
  - IDLE, EXEC, DIV_WAIT, RESP. Reset state is IDLE.
  - in_ready = (state==IDLE) || (state==RESP && res_ready).
- Reset (rst low, asynchronous):
  - All ALU control outputs, alu_a and alu_b go to 0; alu_mux=000 (ADD).
  - res_valid=0, res_data=0, res_rem=0, res_err=0; counter=0.
- Accept (in_valid && in_ready):
  - Register in_a/in_b into alu_a/alu_b and decode in_op into the control registers.
  - Go to EXEC next cycle.
- EXEC, non-DIV op: capture alu_out into res_data, clear res_rem and res_err, go to RESP. Accept-to-res_valid latency is 2 cycles.
- EXEC, DIV op: counter=1, go to DIV_WAIT.
- DIV_WAIT:
  - Controls and operands are held unchanged.
  - Each cycle: if div_stall==0, capture alu_out and alu_rem, res_err=0, go to RESP. Otherwise counter++.
  - When the counter reaches DIV_MAX_CYCLES with div_stall still 1: res_data=16'hFFFF, res_rem=0, res_err=1, go to RESP.
  - The div_stall sample in EXEC is ignored; the divider may report stale ready that cycle.
- RESP:
  - res_valid=1; result fields are stable until the handshake.
  - On res_ready: res_valid drops, unless a new op is accepted the same cycle (back-to-back); state goes to EXEC or IDLE accordingly.
- ALU controls keep their last values in IDLE.
- Stable control is required because the ALU asserts divide enable combinationally from alu_mux==011.
- in_* are ignored when in_ready=0. There is no queuing and no op reordering.
- Reset mid-divide: immediate return to IDLE with outputs cleared; the ALU is left at mux 000, which deasserts divide enable.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- Defined: a DIV with in_b==0 is not sent to the ALU.
  - alu_mux is set to 000 instead of 011.
  - EXEC goes directly to RESP with res_data=16'hFFFF, res_rem=in_a (registered), res_err=1.
  - Latency is 2 cycles.
- Undefined: a DIV with in_b==0 goes to the ALU like any other DIV. The response is whatever the divider returns, or the timeout error if it never completes.

Test Plan:
- ADD a=0x1234 b=0x0011, res_ready=1 -> res_valid exactly 2 cycles after accept, res_data=0x1245, res_err=0, in_ready high in the RESP cycle.
- DIV a=100 b=7, div_stall high 17 cycles -> alu_mux=011 held throughout, res_data=14, res_rem=2, res_err=0, no response before div_stall falls.
- DIV with div_stall stuck at 1 -> after DIV_MAX_CYCLES: res_err=1, res_data=0xFFFF.
- Back-to-back: SLT then XOR with res_ready=1 -> second accepted in the first's RESP cycle. SLT a=5 b=3 returns 0x0000 or 0x0001 per the ALU flag; XOR 0xFF00^0x0FF0 returns 0xF0F0.
- Backpressure: res_ready=0 for 5 cycles -> res_valid and res_data stable, in_ready=0, in_valid ignored.
- Reset asserted in DIV_WAIT -> all outputs zero immediately, alu_mux=000. A new op is accepted normally after release. With DIV_ZERO_TRAP_EN, DIV b=0 a=9 -> res_err=1, res_rem=9, alu_mux never 011.
